// File: rtl/serial_arith_pkg.sv
// Shared encoding and parameter limits for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_is_legal(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// One-bit full adder cell: combinational sum and carry of three input bits.
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell walks the operands LSB first,
// carry held in a register, result shifted into sum from the MSB end.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done,
    output logic             busy
);

    if (!width_is_legal(WIDTH)) begin : g_width_illegal
        $error("serial_adder: WIDTH must be within 2..32");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   sum_d;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;
    logic               busy_q;
    logic               fa_sum;
    logic               fa_carry;

    fulladder u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (fa_sum),
        .c_o (fa_carry)
    );

    // After WIDTH shifts the first computed bit has reached position 0.
    assign sum_d = {fa_sum, sum_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    carry_q <= fa_carry;
                    sum_q   <= sum_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = carry_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed and random operations on an 8-bit instance,
// exhaustive operands on a 4-bit instance, against an arithmetic reference.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start8, cin8, done8, busy8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, done4, busy4, cout4;
    logic [3:0] a4, b4, sum4;

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .cout(cout8), .done(done8), .busy(busy8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .sum(sum4), .cout(cout4), .done(done4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation; a second start pulse is injected at sample glitch_at (if >= 0).
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input int glitch_at, input string tag);
        int dk, ndone, nbusy;
        logic [8:0] exp, res;
        exp = 9'(av) + 9'(bv) + 9'(cv);
        dk = -1; ndone = 0; nbusy = 0; res = '0;
        @(negedge clk);
        start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
        @(negedge clk);
        start8 = 1'b0; a8 = ~av; b8 = ~bv; cin8 = ~cv;
        for (int k = 0; k < 12; k++) begin
            if (k == glitch_at) begin
                start8 = 1'b1; a8 = 8'h11;
            end else begin
                start8 = 1'b0;
            end
            if (done8) begin
                ndone++;
                if (dk < 0) begin
                    dk = k;
                    res = {cout8, sum8};
                end
            end
            if (busy8) nbusy++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(dk), 32'd8);
        chk({tag, "_ndone"}, 32'(ndone), 32'd1);
        chk({tag, "_busy"}, 32'(nbusy), 32'd8);
        chk({tag, "_result"}, 32'(res), 32'(exp));
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic cv);
        int dk, nbusy;
        logic [4:0] exp, res;
        exp = 5'(av) + 5'(bv) + 5'(cv);
        dk = -1; nbusy = 0; res = '0;
        @(negedge clk);
        start4 = 1'b1; a4 = av; b4 = bv; cin4 = cv;
        @(negedge clk);
        start4 = 1'b0; a4 = ~av; b4 = ~bv; cin4 = ~cv;
        for (int k = 0; k < 6; k++) begin
            if (done4 && dk < 0) begin
                dk = k;
                res = {cout4, sum4};
            end
            if (busy4) nbusy++;
            @(negedge clk);
        end
        chk("w4_latency", 32'(dk), 32'd4);
        chk("w4_busy", 32'(nbusy), 32'd4);
        chk($sformatf("w4_sum_%0h_%0h_%0d", av, bv, cv), 32'(res), 32'(exp));
    endtask

    initial begin
        int k1, k2;
        logic [8:0] r1, r2;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        #1;
        chk("reset_sum", 32'(sum8), 32'd0);
        chk("reset_ctrl", {29'd0, cout8, done8, busy8}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op8(8'h00, 8'h00, 1'b0, -1, "zero");
        op8(8'hFF, 8'h01, 1'b0, -1, "ff_01");
        op8(8'hFF, 8'hFF, 1'b1, -1, "all_ones");
        op8(8'hA5, 8'h5A, 1'b1, 3, "start_in_run");

        // Back-to-back: start held high through the first DONE.
        k1 = -1; k2 = -1; r1 = '0; r2 = '0;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done8) begin
                if (k1 < 0) begin
                    k1 = k; r1 = {cout8, sum8};
                    a8 = 8'h10; b8 = 8'h20;
                end else if (k2 < 0) begin
                    k2 = k; r2 = {cout8, sum8};
                end
            end
            if (k1 >= 0 && k == k1 + 1) start8 = 1'b0;
        end
        chk("b2b_first", 32'(r1), 32'h007);
        chk("b2b_second", 32'(r2), 32'h030);
        chk("b2b_spacing", 32'(k2 - k1), 32'd9);

        // Reset in the middle of RUN aborts the operation.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_sum", 32'(sum8), 32'd0);
        chk("abort_ctrl", {29'd0, cout8, done8, busy8}, 32'd0);
        k1 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done8 || busy8) k1++;
            if (k == 2) rst_n = 1'b1;
        end
        chk("abort_no_done", 32'(k1), 32'd0);
        op8(8'h7F, 8'h01, 1'b0, -1, "after_reset");

        for (int i = 0; i < 24; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom),
                int'($urandom_range(0, 7)) - 1, "rand");
        end

        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int cv = 0; cv < 2; cv++) begin
                    op4(4'(av), 4'(bv), 1'(cv));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
